// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative AES InvSubBytes, LANES bytes per clock, valid/ready out
// Optional forward S-box per lane when INV_SUB_BYTES_FWD_EN is defined.
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] invSubBytes_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] after_invSubBytes
`ifdef INV_SUB_BYTES_FWD_EN
  ,
  input  logic         fwd_mode
`endif
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int GW     = 8 * LANES;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [127:0]    work;
  logic [CW-1:0]   cnt;
  logic            load, step;
  logic [GW-1:0]   grp_cur, grp_new;

  // Row-per-high-nibble ROM: each row holds 16 table entries, entry 0 in the MSBs.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [127:0] row;
    case (a[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    return row[8*(15 - int'(a[3:0])) +: 8];
  endfunction

`ifdef INV_SUB_BYTES_FWD_EN
  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [127:0] row;
    case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[8*(15 - int'(a[3:0])) +: 8];
  endfunction

  logic fwd_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fwd_q <= 1'b0;
    else if (load) fwd_q <= fwd_mode;
  end
`endif

  assign load = (state == IDLE) && in_valid && !flush;
  assign step = (state == BUSY) && !flush;

  // Group cnt covers bytes cnt*LANES .. cnt*LANES+LANES-1, byte 0 at the MSB end.
  assign grp_cur = work[127 - int'(cnt)*GW -: GW];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef INV_SUB_BYTES_FWD_EN
    assign grp_new[GW-1-8*l -: 8] = fwd_q ? fwd_sbox(grp_cur[GW-1-8*l -: 8])
                                          : inv_sbox(grp_cur[GW-1-8*l -: 8]);
`else
    assign grp_new[GW-1-8*l -: 8] = inv_sbox(grp_cur[GW-1-8*l -: 8]);
`endif
  end

  if (GROUPS > 1) begin : g_cnt
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     cnt_q <= '0;
      else if (load)                  cnt_q <= '0;
      else if (step && cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
    end
    assign cnt = cnt_q;
  end else begin : g_no_cnt
    assign cnt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
    end else begin
      state <= state_nxt;
      if (load)      work <= invSubBytes_in;
      else if (step) work[127 - int'(cnt)*GW -: GW] <= grp_new;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = BUSY;
        BUSY:    if (cnt == LAST) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign in_ready          = (state == IDLE);
  assign out_valid         = (state == DONE);
  assign after_invSubBytes = work;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - self-checking bench for inv_sub_bytes_iter, LANES 1..16
// Reference S-boxes are derived from GF(2^8) inversion plus the affine map.
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush     [5];
  logic         in_valid  [5];
  logic         in_ready  [5];
  logic [127:0] din       [5];
  logic         out_valid [5];
  logic         out_ready [5];
  logic [127:0] dout      [5];
`ifdef INV_SUB_BYTES_FWD_EN
  logic         fwd       [5];
`endif

  always #5 clk = ~clk;

  // Instance k runs with LANES = 1 << k (1, 2, 4, 8, 16).
  for (genvar k = 0; k < 5; k++) begin : g_dut
    inv_sub_bytes_iter #(.LANES(1 << k)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush             (flush[k]),
      .in_valid          (in_valid[k]),
      .in_ready          (in_ready[k]),
      .invSubBytes_in    (din[k]),
      .out_valid         (out_valid[k]),
      .out_ready         (out_ready[k]),
      .after_invSubBytes (dout[k])
`ifdef INV_SUB_BYTES_FWD_EN
      ,
      .fwd_mode          (fwd[k])
`endif
    );
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] fsb [256];
  logic [7:0] isb [256];

  typedef struct {
    int           k;
    logic [127:0] d;
    logic [127:0] exp;
    int           lat;
  } vec_t;
  vec_t vt [$];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int n);
    logic [15:0] w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] sbox_model(logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_block(logic [127:0] d, logic f);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = f ? fsb[d[127-8*i -: 8]] : isb[d[127-8*i -: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    while (out_valid[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Accept one block, measure edges from accept to out_valid, then complete the handshake.
  task automatic run_block(input int k, input logic [127:0] d, input logic f,
                           output logic [127:0] q, output int lat);
    @(negedge clk);
    din[k] = d; in_valid[k] = 1'b1; out_ready[k] = 1'b0;
`ifdef INV_SUB_BYTES_FWD_EN
    fwd[k] = f;
`endif
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    wait_valid(k, lat);
    q = dout[k];
    @(negedge clk); out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  logic [127:0] q, held, ramp;
  int lat;
  bit ever;

  initial begin
    for (int k = 0; k < 5; k++) begin
      flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0; din[k] = '0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd[k] = 1'b0;
`endif
    end
    for (int i = 0; i < 256; i++) fsb[i] = sbox_model(8'(i));
    for (int i = 0; i < 256; i++) isb[fsb[i]] = 8'(i);

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("reset_in_ready", 128'(in_ready[2]), 128'd1);
    check("reset_out_valid", 128'(out_valid[2]), 128'd0);
    check("reset_data", dout[2], 128'h0);

    ramp = 128'h000102030405060708090a0b0c0d0e0f;
    vt.push_back('{2, {16{8'h63}}, 128'h0, 4});
    vt.push_back('{2, {16{8'h00}}, {16{8'h52}}, 4});
    vt.push_back('{2, {16{8'h16}}, {16{8'hff}}, 4});
    for (int k = 0; k < 5; k++) vt.push_back('{k, ramp, model_block(ramp, 1'b0), 16 >> k});
    for (int r = 0; r < 10; r++) begin
      int k = $urandom_range(0, 4);
      logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
      vt.push_back('{k, d, model_block(d, 1'b0), 16 >> k});
    end
    foreach (vt[i]) begin
      run_block(vt[i].k, vt[i].d, 1'b0, q, lat);
      check($sformatf("vec%0d_data", i), q, vt[i].exp);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vt[i].lat));
    end

    // Backpressure: DONE held for 10 cycles with a stray in_valid pulse.
    @(negedge clk); din[2] = ramp; in_valid[2] = 1'b1;
    @(posedge clk); #1 in_valid[2] = 1'b0;
    wait_valid(2, lat);
    held = dout[2];
    check("bp_data", held, model_block(ramp, 1'b0));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid[2] = (c == 4); din[2] = {16{8'h63}};
      @(posedge clk); #1;
      check("bp_hold_valid", 128'(out_valid[2]), 128'd1);
      check("bp_hold_ready", 128'(in_ready[2]), 128'd0);
      check("bp_hold_data", dout[2], held);
    end
    @(negedge clk); in_valid[2] = 1'b0; out_ready[2] = 1'b1;
    @(posedge clk); #1 out_ready[2] = 1'b0;
    check("bp_release_valid", 128'(out_valid[2]), 128'd0);
    check("bp_release_ready", 128'(in_ready[2]), 128'd1);
    @(negedge clk); din[2] = {16{8'h00}}; in_valid[2] = 1'b1;
    @(posedge clk); #1 in_valid[2] = 1'b0;
    check("bp_next_accept", 128'(in_ready[2]), 128'd0);
    wait_valid(2, lat);
    check("bp_next_data", dout[2], {16{8'h52}});
    @(negedge clk); out_ready[2] = 1'b1;
    @(posedge clk); #1 out_ready[2] = 1'b0;

    // Flush in the second BUSY cycle.
    @(negedge clk); din[2] = ramp; in_valid[2] = 1'b1;
    @(posedge clk); #1 in_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk); flush[2] = 1'b1;
    @(posedge clk); #1 flush[2] = 1'b0;
    check("flush_idle", 128'(in_ready[2]), 128'd1);
    ever = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid[2]) ever = 1'b1;
    end
    check("flush_no_valid", 128'(ever), 128'd0);

    // Flush beats a simultaneous accept.
    @(negedge clk); in_valid[2] = 1'b1; flush[2] = 1'b1;
    @(posedge clk); #1 in_valid[2] = 1'b0; flush[2] = 1'b0;
    check("flush_vs_accept", 128'(in_ready[2]), 128'd1);

    // Asynchronous reset in BUSY.
    @(negedge clk); din[2] = ramp; in_valid[2] = 1'b1;
    @(posedge clk); #1 in_valid[2] = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 128'(in_ready[2]), 128'd1);
    check("arst_out_valid", 128'(out_valid[2]), 128'd0);
    check("arst_data", dout[2], 128'h0);
    @(negedge clk); rst_n = 1'b1;

`ifdef INV_SUB_BYTES_FWD_EN
    run_block(2, {16{8'h00}}, 1'b1, q, lat);
    check("fwd_00", q, {16{8'h63}});
    run_block(2, {16{8'h01}}, 1'b1, q, lat);
    check("fwd_01", q, {16{8'h7c}});
    @(negedge clk); din[2] = ramp; in_valid[2] = 1'b1; fwd[2] = 1'b0;
    @(posedge clk); #1 in_valid[2] = 1'b0;
    @(negedge clk); fwd[2] = 1'b1;
    @(negedge clk); fwd[2] = 1'b0;
    @(negedge clk); fwd[2] = 1'b1;
    wait_valid(2, lat);
    check("fwd_toggle", dout[2], model_block(ramp, 1'b0));
    @(negedge clk); out_ready[2] = 1'b1; fwd[2] = 1'b0;
    @(posedge clk); #1 out_ready[2] = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
